// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: a valid/ready input channel carrying a
// binary value and a valid/ready output channel carrying the BCD result.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_sign;
  logic                  out_ovf;

  // Producer of values / consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd, out_sign, out_ovf
  );

  // The converter itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd, out_sign, out_ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// Accepts a value in IDLE, shifts it through the BCD register for BIN_W
// cycles, then presents the result in DONE until the consumer takes it.
// The bit falling off the top digit is collected as a sticky overflow flag,
// so out_bcd always holds the magnitude mod 10^DIGITS as valid BCD.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  bin2bcd_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ovf_q,   ovf_d;
  logic               sign_q,  sign_d;

  logic               in_neg;
  logic [BIN_W-1:0]   in_mag;
  logic [BCD_W-1:0]   bcd_adj;

  // Two's complement negation in BIN_W bits maps the most negative value
  // onto 2^(BIN_W-1), which the unsigned shift register holds exactly.
  assign in_neg = (SIGNED != 0) && bus.in_data[BIN_W-1];
  assign in_mag = in_neg ? ((~bus.in_data) + BIN_W'(1)) : bus.in_data;

  // Add-3 correction, independently per digit (no inter-digit carry).
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5)
                              ? bcd_q[4*gi +: 4] + 4'd3
                              : bcd_q[4*gi +: 4];
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d = in_mag;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          sign_d  = in_neg;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_d = shift_q << 1;
        ovf_d   = ovf_q | bcd_adj[BCD_W-1];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_bcd   = bcd_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_sign  = (SIGNED != 0) ? sign_q : 1'b0;

endmodule
